// File: rtl/config_byte_streamer.sv
// Transmit side of the configId/configData firmware-load bus: buffers one host image,
// then replays it as a gap-free burst while the global tracing enable is held low.
module config_byte_streamer #(
    parameter int unsigned BUF_DEPTH    = 64,
    parameter logic [7:0]  IDLE_ID      = 8'hFF,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned LEN_W        = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trace_en,
    input  logic             cfg_start,
    input  logic [7:0]       cfg_target_id,
    input  logic [LEN_W-1:0] cfg_length,
    input  logic             cfg_abort,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             tracing,
    output logic [7:0]       configId,
    output logic [7:0]       configData
);

    localparam int unsigned ADDR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [LEN_W-1:0]   MaxLen    = LEN_W'(BUF_DEPTH);
    localparam logic [DRAIN_W-1:0] DrainLast = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [LEN_W-1:0]   LenOne    = LEN_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StQuiesce,
        StStream,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         target_q, target_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   wr_q, wr_d;
    logic [LEN_W-1:0]   rd_q, rd_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               wr_en;

    logic [7:0] mem_q [BUF_DEPTH];

    logic       byte_ready_q, byte_ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       tracing_q, tracing_d;
    logic [7:0] config_id_q, config_id_d;
    logic [7:0] config_data_q, config_data_d;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        len_d         = len_q;
        wr_d          = wr_q;
        rd_d          = rd_q;
        drain_d       = drain_q;
        wr_en         = 1'b0;
        err_d         = 1'b0;
        done_d        = 1'b0;
        config_data_d = 8'h00;

        case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    if ((cfg_length > MaxLen) || (cfg_target_id == IDLE_ID)) begin
                        err_d = 1'b1;
                    end else begin
                        target_d = cfg_target_id;
                        len_d    = cfg_length;
                        wr_d     = '0;
                        rd_d     = '0;
                        state_d  = StLoad;
                    end
                end
            end

            StLoad: begin
                if (cfg_abort) begin
                    wr_d    = '0;
                    state_d = StIdle;
                end else begin
                    wr_en = byte_valid && byte_ready_q;
                    if (wr_en) begin
                        wr_d = wr_q + LenOne;
                    end
                    // A zero-length image falls through on the first LOAD cycle.
                    if (wr_d == len_q) begin
                        drain_d = '0;
                        state_d = StQuiesce;
                    end
                end
            end

            StQuiesce: begin
                if (drain_q == DrainLast) begin
                    if (len_q == '0) begin
                        state_d = StGap;
                    end else begin
                        rd_d          = '0;
                        config_data_d = mem_q[0];
                        state_d       = StStream;
                    end
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end

            StStream: begin
                if (rd_q == len_q - LenOne) begin
                    rd_d    = '0;
                    state_d = StGap;
                end else begin
                    rd_d          = rd_q + LenOne;
                    config_data_d = mem_q[rd_d[ADDR_W-1:0]];
                end
            end

            StGap: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they always match the current state.
        byte_ready_d = (state_d == StLoad) && (wr_d < len_d);
        busy_d       = (state_d != StIdle);
        tracing_d    = ((state_d == StIdle) || (state_d == StLoad)) ? trace_en : 1'b0;
        config_id_d  = (state_d == StStream) ? target_d : IDLE_ID;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            target_q      <= IDLE_ID;
            len_q         <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            drain_q       <= '0;
            byte_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            tracing_q     <= 1'b0;
            config_id_q   <= IDLE_ID;
            config_data_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            len_q         <= len_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            drain_q       <= drain_d;
            byte_ready_q  <= byte_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            tracing_q     <= tracing_d;
            config_id_q   <= config_id_d;
            config_data_q <= config_data_d;
        end
    end

    // Image storage needs no reset; only written bytes are ever replayed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[ADDR_W-1:0]] <= byte_data;
        end
    end

    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign tracing    = tracing_q;
    assign configId   = config_id_q;
    assign configData = config_data_q;

endmodule

// File: tb/tb_config_byte_streamer.sv
// Directed bench for config_byte_streamer: loads, bursts, rejects, abort, empty image, resets.
module tb_config_byte_streamer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       trace_en = 1'b0;
    logic       cfg_start = 1'b0;
    logic [7:0] cfg_target_id = 8'h00;
    logic [6:0] cfg_length = 7'd0;
    logic       cfg_abort = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;

    int n_cmp = 0;
    int n_mis = 0;

    bit mon_en = 1'b0;
    int mon_low = 0;
    int mon_hit = 0;
    int mon_done = 0;

    always #5 clk = ~clk;

    config_byte_streamer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_en     (trace_en),
        .cfg_start    (cfg_start),
        .cfg_target_id(cfg_target_id),
        .cfg_length   (cfg_length),
        .cfg_abort    (cfg_abort),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .tracing      (tracing),
        .configId     (configId),
        .configData   (configData)
    );

    // Watches the abort scenario for any drop of tracing, use of the target ID or done.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!tracing) mon_low++;
            if (configId == 8'h02) mon_hit++;
            if (done) mon_done++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [7:0] tgt, input logic [6:0] len);
        cfg_start     = 1'b1;
        cfg_target_id = tgt;
        cfg_length    = len;
        tick;
        cfg_start     = 1'b0;
    endtask

    task automatic feed(input int len, input bit bubble, input logic [7:0] base,
                        output int cycles);
        int  i;
        bit  rdy;
        i      = 0;
        cycles = 0;
        while (i < len && cycles < 4 * len + 8) begin
            rdy        = byte_ready;
            byte_valid = bubble ? (cycles % 2 == 0) : 1'b1;
            byte_data  = base + 8'(i);
            tick;
            if (byte_valid && rdy) i++;
            cycles++;
        end
        byte_valid = 1'b0;
    endtask

    // Entered in the first QUIESCE cycle; walks drain, burst, gap and the done cycle.
    task automatic check_burst(input string name, input logic [7:0] tgt, input int len,
                               input logic [7:0] base);
        for (int q = 0; q < 3; q++) begin
            check_eq($sformatf("%s_quiesce%0d_trace", name, q), tracing, 0);
            check_eq($sformatf("%s_quiesce%0d_id", name, q), configId, 8'hFF);
            tick;
        end
        for (int k = 0; k < len; k++) begin
            check_eq($sformatf("%s_stream%0d_id", name, k), configId, tgt);
            check_eq($sformatf("%s_stream%0d_data", name, k), configData, base + 8'(k));
            check_eq($sformatf("%s_stream%0d_trace", name, k), tracing, 0);
            tick;
        end
        check_eq({name, "_gap_id"}, configId, 8'hFF);
        check_eq({name, "_gap_trace"}, tracing, 0);
        check_eq({name, "_gap_busy"}, busy, 1);
        check_eq({name, "_gap_done"}, done, 0);
        tick;
        check_eq({name, "_done"}, done, 1);
        check_eq({name, "_idle_busy"}, busy, 0);
        check_eq({name, "_idle_trace"}, tracing, 1);
        tick;
        check_eq({name, "_done_once"}, done, 0);
    endtask

    initial begin
        int cyc;

        // Reset asserted between clock edges must act at once.
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst_trace", tracing, 0);
        check_eq("rst_id", configId, 8'hFF);
        check_eq("rst_data", configData, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", byte_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick;

        // Idle tracing follows trace_en one cycle late.
        trace_en = 1'b1;
        check_eq("idle_trace_lag", tracing, 0);
        tick;
        check_eq("idle_trace_follow", tracing, 1);

        // Back-to-back 24-byte load to target 3.
        start_cmd(8'h03, 7'd24);
        check_eq("t2_load_busy", busy, 1);
        check_eq("t2_load_ready", byte_ready, 1);
        check_eq("t2_load_trace", tracing, 1);
        check_eq("t2_load_id", configId, 8'hFF);
        feed(24, 1'b0, 8'h00, cyc);
        check_eq("t2_load_cycles", cyc, 24);
        check_eq("t2_ready_after", byte_ready, 0);
        check_burst("t2", 8'h03, 24, 8'h00);

        // Same length with alternating bubbles: burst must still be gap-free.
        start_cmd(8'h03, 7'd24);
        feed(24, 1'b1, 8'h80, cyc);
        check_eq("t3_load_cycles", cyc, 47);
        check_burst("t3", 8'h03, 24, 8'h80);

        // Rejected starts.
        start_cmd(8'h03, 7'd65);
        check_eq("t4_len_err", err, 1);
        check_eq("t4_len_busy", busy, 0);
        tick;
        check_eq("t4_len_err_pulse", err, 0);
        start_cmd(8'hFF, 7'd4);
        check_eq("t4_id_err", err, 1);
        check_eq("t4_id_busy", busy, 0);
        tick;
        check_eq("t4_id_err_pulse", err, 0);
        start_cmd(8'h05, 7'd2);
        check_eq("t4_busy_load", busy, 1);
        start_cmd(8'h03, 7'd65);
        check_eq("t4_busy_no_err", err, 0);
        check_eq("t4_busy_still", busy, 1);
        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        check_eq("t4_abort_idle", busy, 0);
        check_eq("t4_abort_done", done, 0);
        check_eq("t4_abort_err", err, 0);

        // Abort after 10 of 20 bytes.
        mon_en = 1'b1;
        start_cmd(8'h02, 7'd20);
        feed(10, 1'b0, 8'h50, cyc);
        check_eq("t5_still_ready", byte_ready, 1);
        cfg_abort = 1'b1;
        tick;
        cfg_abort = 1'b0;
        check_eq("t5_abort_busy", busy, 0);
        check_eq("t5_abort_ready", byte_ready, 0);
        repeat (4) tick;
        mon_en = 1'b0;
        check_eq("t5_trace_drops", mon_low, 0);
        check_eq("t5_target_cycles", mon_hit, 0);
        check_eq("t5_done_pulses", mon_done, 0);

        // Empty image: drain, gap, done, never the target ID.
        start_cmd(8'h07, 7'd0);
        check_eq("t6_load_busy", busy, 1);
        check_eq("t6_load_ready", byte_ready, 0);
        tick;
        check_burst("t6", 8'h07, 0, 8'h00);

        // Reset in the middle of a burst.
        start_cmd(8'h09, 7'd8);
        feed(8, 1'b0, 8'h30, cyc);
        repeat (3) tick;
        check_eq("t7_stream_id", configId, 8'h09);
        check_eq("t7_stream_d0", configData, 8'h30);
        tick;
        check_eq("t7_stream_d1", configData, 8'h31);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t7_rst_id", configId, 8'hFF);
        check_eq("t7_rst_trace", tracing, 0);
        check_eq("t7_rst_busy", busy, 0);
        check_eq("t7_rst_data", configData, 8'h00);
        check_eq("t7_rst_done", done, 0);
        #2 reset_n = 1'b1;
        tick;
        check_eq("t7_post_busy", busy, 0);
        check_eq("t7_post_trace", tracing, 1);
        check_eq("t7_post_id", configId, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
